serial_sub8: RTL

//  Bit-serial two's-complement subtractor: computes A - B - Bin one bit per clock, LSB first.
//  It reuses one full-adder cell with B inverted and a registered carry/borrow.
//  It is the inverse of the 8-bit ripple-carry adder stage in the datapath.

---
 rtl/serial_sub8.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: A - B - Bin, LSB first, through one full-adder cell
// fed with ~B and a registered carry (carry = ~borrow).
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [WIDTH:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, d_sh_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             a_msb_q, b_msb_q;
  logic             busy_q, done_q, bout_q, ovf_q;
  logic [WIDTH-1:0] diff_q;

  logic             nb0, s_d, c_d, last;
  logic [WIDTH-1:0] d_sh_d;

  assign nb0    = ~b_sh_q[0];
  assign s_d    = a_sh_q[0] ^ nb0 ^ c_q;
  assign c_d    = (a_sh_q[0] & nb0) | (a_sh_q[0] & c_q) | (nb0 & c_q);
  assign d_sh_d = {s_d, d_sh_q[WIDTH-1:1]};
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          d_sh_q <= d_sh_d;
          c_q    <= c_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= d_sh_d;
            bout_q  <= ~c_d;
            // s_d is the MSB of the final difference
            ovf_q   <= (a_msb_q != b_msb_q) && (s_d != a_msb_q);
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            a_sh_q  <= a;
            b_sh_q  <= b;
            d_sh_q  <= '0;
            c_q     <= ~bin;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign bout   = bout_q;
  assign ovf    = ovf_q;
  assign result = {~bout_q, diff_q};

endmodule
